seg_stopwatch_ctrl: RTL and testbench

- Key-driven stopwatch controller that sequences the two-value seg display driver.
- Consumes single-cycle key pulses from the key debouncer.
- Holds a run/pause/clear state machine and a prescaler.
- Produces minutes (dat1) and seconds (dat2) as binary values for the seg driver's dat1/dat2 inputs.

---
 rtl/seg_stopwatch_ctrl.sv | 123 ++++++++++++
 tb/tb_seg_stopwatch_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg_stopwatch_ctrl.sv
// Key-driven stopwatch controller: run/pause/clear FSM plus a one-second prescaler,
// producing binary minutes (dat1) and seconds (dat2) for the two-value seg driver.
module seg_stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned MIN_MAX  = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_flag,
    input  logic       clr_flag,
    output logic [7:0] dat1,
    output logic [7:0] dat2,
    output logic       running,
    output logic       full,
    output logic [3:0] state
);

    localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    MIN_LAST   = 8'(MIN_MAX);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        RUN   = 4'b0010,
        PAUSE = 4'b0100,
        FULL  = 4'b1000
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    dat1_d, dat2_d;
    logic          tick;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        presc_d = presc_q;
        dat1_d  = dat1;
        dat2_d  = dat2;
        tick    = 1'b0;

        case (state_q)
            IDLE: begin
                dat1_d  = 8'd0;
                dat2_d  = 8'd0;
                presc_d = '0;
                if (start_flag && !clr_flag) state_d = RUN;
            end

            RUN: begin
                if (clr_flag) begin
                    state_d = IDLE;
                    presc_d = '0;
                    dat1_d  = 8'd0;
                    dat2_d  = 8'd0;
                end else begin
                    tick    = (presc_q == PRESC_LAST);
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (start_flag) state_d = PAUSE;
                    if (tick) begin
                        if (dat2 < 8'd59) begin
                            dat2_d = dat2 + 8'd1;
                        end else begin
                            dat2_d = 8'd0;
                            dat1_d = dat1 + 8'd1;
                        end
                        // Reaching MIN_MAX:59 overrides any simultaneous pause request.
                        if (dat1 == MIN_LAST && dat2 == 8'd58) state_d = FULL;
                    end
                end
            end

            PAUSE: begin
                if (clr_flag) begin
                    state_d = IDLE;
                    presc_d = '0;
                    dat1_d  = 8'd0;
                    dat2_d  = 8'd0;
                end else if (start_flag) begin
                    state_d = RUN;
                end
            end

            FULL: begin
                presc_d = '0;
                if (clr_flag) begin
                    state_d = IDLE;
                    dat1_d  = 8'd0;
                    dat2_d  = 8'd0;
                end
            end

            default: begin
                state_d = IDLE;
                presc_d = '0;
                dat1_d  = 8'd0;
                dat2_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            dat1    <= 8'd0;
            dat2    <= 8'd0;
            running <= 1'b0;
            full    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            dat1    <= dat1_d;
            dat2    <= dat2_d;
            running <= (state_d == RUN);
            full    <= (state_d == FULL);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_seg_stopwatch_ctrl.sv
// Directed self-checking bench for seg_stopwatch_ctrl with TICK_DIV=4, MIN_MAX=1.
module tb_seg_stopwatch_ctrl;

    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_RUN   = 4'b0010;
    localparam logic [3:0] S_PAUSE = 4'b0100;
    localparam logic [3:0] S_FULL  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_flag;
    logic       clr_flag;
    logic [7:0] dat1;
    logic [7:0] dat2;
    logic       running;
    logic       full;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    seg_stopwatch_ctrl #(.TICK_DIV(4), .MIN_MAX(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_flag(start_flag),
        .clr_flag  (clr_flag),
        .dat1      (dat1),
        .dat2      (dat2),
        .running   (running),
        .full      (full),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int m, input int s, input logic [3:0] st,
                             input logic run_e, input logic full_e);
        check({tag, ".dat1"}, 32'(dat1), 32'(m));
        check({tag, ".dat2"}, 32'(dat2), 32'(s));
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".running"}, 32'(running), 32'(run_e));
        check({tag, ".full"}, 32'(full), 32'(full_e));
    endtask

    task automatic pulse_start();
        start_flag = 1'b1;
        step(1);
        start_flag = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flag = 1'b1;
        step(1);
        clr_flag = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start_flag = 1'b0;
        clr_flag   = 1'b0;
        #1;
        step(2);
        rst_n = 1'b1;
        check_all("reset", 0, 0, S_IDLE, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            step(1);
            check_all("idle_hold", 0, 0, S_IDLE, 1'b0, 1'b0);
        end

        pulse_clr();
        check_all("idle_clr_noop", 0, 0, S_IDLE, 1'b0, 1'b0);

        // Start sampled at edge k; seconds land at k+4, k+8, k+12.
        pulse_start();
        step(1);
        check_all("start_k1", 0, 0, S_RUN, 1'b1, 1'b0);
        step(2);
        check("start_k3.dat2", 32'(dat2), 32'd0);
        step(1);
        check("start_k4.dat2", 32'(dat2), 32'd1);
        step(4);
        check("start_k8.dat2", 32'(dat2), 32'd2);
        step(4);
        check_all("start_k12", 0, 3, S_RUN, 1'b1, 1'b0);

        // Seconds wrap: 240 RUN cycles in total reach 01:00.
        step(224);
        check_all("wrap_0059", 0, 59, S_RUN, 1'b1, 1'b0);
        step(3);
        check("wrap_0059_hold.dat2", 32'(dat2), 32'd59);
        step(1);
        check_all("wrap_0100", 1, 0, S_RUN, 1'b1, 1'b0);

        // start+clr together in RUN: clear wins.
        start_flag = 1'b1;
        clr_flag   = 1'b1;
        step(1);
        start_flag = 1'b0;
        clr_flag   = 1'b0;
        check_all("start_clr_collide", 0, 0, S_IDLE, 1'b0, 1'b0);

        // Pause after two RUN cycles; prescaler held at 2.
        pulse_start();
        step(1);
        start_flag = 1'b1;
        step(1);
        start_flag = 1'b0;
        check_all("pause_enter", 0, 0, S_PAUSE, 1'b0, 1'b0);
        step(10);
        check_all("pause_hold", 0, 0, S_PAUSE, 1'b0, 1'b0);
        pulse_start();
        check("resume.state", 32'(state), 32'(S_RUN));
        step(1);
        check("resume_r1.dat2", 32'(dat2), 32'd0);
        step(1);
        check("resume_r2.dat2", 32'(dat2), 32'd1);

        // Tick and start on the same edge: increment lands, state pauses.
        step(3);
        start_flag = 1'b1;
        step(1);
        start_flag = 1'b0;
        check_all("tick_start", 0, 2, S_PAUSE, 1'b0, 1'b0);
        pulse_start();
        step(3);
        check("tick_start_resume3.dat2", 32'(dat2), 32'd2);
        step(1);
        check("tick_start_resume4.dat2", 32'(dat2), 32'd3);

        // Reset mid-run at 00:37 with a partial prescaler count.
        step(136);
        check_all("run_0037", 0, 37, S_RUN, 1'b1, 1'b0);
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_all("mid_reset", 0, 0, S_IDLE, 1'b0, 1'b0);
        pulse_start();
        step(3);
        check("post_reset3.dat2", 32'(dat2), 32'd0);
        step(1);
        check("post_reset4.dat2", 32'(dat2), 32'd1);
        pulse_clr();
        check_all("clr_run", 0, 0, S_IDLE, 1'b0, 1'b0);

        // Saturation at MIN_MAX=1: 01:59 after 119 seconds, final tick collides with start.
        pulse_start();
        step(475);
        check_all("sat_0158", 1, 58, S_RUN, 1'b1, 1'b0);
        start_flag = 1'b1;
        step(1);
        start_flag = 1'b0;
        check_all("sat_full", 1, 59, S_FULL, 1'b0, 1'b1);
        pulse_start();
        check_all("sat_start_ignored", 1, 59, S_FULL, 1'b0, 1'b1);
        step(50);
        check_all("sat_hold", 1, 59, S_FULL, 1'b0, 1'b1);
        pulse_clr();
        check_all("sat_clr", 0, 0, S_IDLE, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
